// File: rtl/fft_sdf_ctrl.sv
// fft_sdf_ctrl: frame sequencer for a radix-2 SDF FFT pipeline; admits frames, drains, realigns stages and tags outputs.
module fft_sdf_ctrl #(
  parameter int N_POINT  = 16,
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cnt_en,
  output logic             pipe_clr,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_index,
  output logic             out_first,
  output logic             out_last,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, CLEAR} state_t;
  state_t               state_q, state_d, st;
  logic [LOG2N-1:0]     in_cnt_q, in_cnt_d, k_q, k_d;
  logic [5:0]           drain_q, drain_d, dc;
  logic                 abort_q, abort_d, acc;
  logic [PIPE_LAT-1:0]  sr_q, sr_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  always_comb begin
    // A frame boundary with no follow-on sample is already the first drain cycle, so ready drops immediately.
    st = (state_q == ACTIVE && in_cnt_q == '0 && !in_valid) ? DRAIN : state_q;
    dc = (state_q == DRAIN) ? drain_q : '0;
    in_ready = st == IDLE || st == ACTIVE;
    cnt_en = (st == IDLE && in_valid) || st == ACTIVE || st == DRAIN;
    acc = in_valid && in_ready;
    state_d = st;
    abort_d = 1'b0;
    drain_d = '0;
    if (st == IDLE && in_valid) state_d = ACTIVE;
    if (st == ACTIVE && !in_valid) begin
      state_d = CLEAR;
      abort_d = 1'b1;
    end
    if (st == DRAIN) begin
      drain_d = dc + 6'd1;
      state_d = (dc == 6'(PIPE_LAT - 1)) ? CLEAR : DRAIN;
    end
    if (st == CLEAR) state_d = IDLE;
    in_cnt_d = (state_d == CLEAR) ? '0 : in_cnt_q + LOG2N'(acc);
    sr_d = (state_d == CLEAR) ? '0 : (sr_q << 1) | PIPE_LAT'(acc);
    out_valid = sr_q[PIPE_LAT-1];
    k_d = (state_d == CLEAR) ? '0 : k_q + LOG2N'(out_valid);
    out_first = out_valid && k_q == '0;
    out_last = out_valid && k_q == LOG2N'(N_POINT - 1);
    frame_cnt_d = frame_cnt_q + 8'(out_last);
    frame_cnt = frame_cnt_q;
    pipe_clr = state_q == CLEAR;
    frame_err = pipe_clr && abort_q;
    out_index = '0;
    for (int i = 0; i < LOG2N; i++) out_index[i] = out_valid & k_q[LOG2N-1-i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      abort_q     <= 1'b0;
      sr_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      abort_q     <= abort_d;
      sr_q        <= sr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb_fft_sdf_ctrl: directed cycle-accurate checks of the SDF FFT frame sequencer.
module tb_fft_sdf_ctrl;
  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic       in_ready, cnt_en, pipe_clr, out_valid, out_first, out_last, frame_err;
  logic [3:0] out_index;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0, cyc = 0;
  logic       e_rdy, e_cen, e_clr, e_ov, e_of, e_ol, e_err;
  logic [3:0] e_idx;
  logic [7:0] e_fc;
  logic [3:0] idx_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                               4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
  fft_sdf_ctrl #(.N_POINT(16), .LOG2N(4), .PIPE_LAT(19)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cnt_en(cnt_en),
    .pipe_clr(pipe_clr), .out_valid(out_valid), .out_index(out_index), .out_first(out_first),
    .out_last(out_last), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input logic iv);
    in_valid = iv;
    #1;
    chk1("in_ready", in_ready, e_rdy);
    chk1("cnt_en", cnt_en, e_cen);
    chk1("pipe_clr", pipe_clr, e_clr);
    chk1("out_valid", out_valid, e_ov);
    chk1("out_first", out_first, e_of);
    chk1("out_last", out_last, e_ol);
    chk1("frame_err", frame_err, e_err);
    checks++;
    assert (frame_cnt === e_fc) else begin
      errors++;
      $error("FAIL frame_cnt cyc=%0d observed=%0d expected=%0d", cyc, frame_cnt, e_fc);
    end
    if (e_ov) begin
      checks++;
      assert (out_index === e_idx) else begin
        errors++;
        $error("FAIL out_index cyc=%0d observed=%0d expected=%0d", cyc, out_index, e_idx);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
  endtask
  // Expected waveform for one clean 16-sample frame whose first accept is cycle s.
  task automatic single(input int s);
    e_cen = cyc >= s && cyc <= s + 34;
    e_ov  = cyc >= s + 19 && cyc <= s + 34;
    e_of  = cyc == s + 19;
    e_ol  = cyc == s + 34;
    e_rdy = !(cyc >= s + 16 && cyc <= s + 35);
    e_clr = cyc == s + 35;
    e_err = 1'b0;
    e_fc  = (cyc >= s + 35) ? 8'd1 : 8'd0;
    e_idx = e_ov ? idx_tab[cyc-s-19] : 4'd0;
  endtask
  initial begin
    do_reset();
    while (cyc <= 50) begin
      single(10);
      step(cyc >= 10 && cyc <= 25);
    end
    do_reset();
    while (cyc <= 80) begin
      e_cen = cyc >= 10 && cyc <= 76;
      e_ov  = cyc >= 29 && cyc <= 76;
      e_of  = cyc == 29 || cyc == 45 || cyc == 61;
      e_ol  = cyc == 44 || cyc == 60 || cyc == 76;
      e_rdy = !(cyc >= 58 && cyc <= 77);
      e_clr = cyc == 77;
      e_err = 1'b0;
      e_fc  = (cyc >= 77) ? 8'd3 : (cyc >= 61) ? 8'd2 : (cyc >= 45) ? 8'd1 : 8'd0;
      e_idx = e_ov ? idx_tab[(cyc-29)%16] : 4'd0;
      step(cyc >= 10 && cyc <= 57);
    end
    do_reset();
    while (cyc <= 40) begin
      e_cen = cyc >= 10 && cyc <= 15;
      e_ov = 1'b0; e_of = 1'b0; e_ol = 1'b0; e_idx = 4'd0; e_fc = 8'd0;
      e_rdy = cyc != 16;
      e_clr = cyc == 16;
      e_err = cyc == 16;
      step(cyc >= 10 && cyc <= 14);
    end
    do_reset();
    while (cyc <= 60) begin
      e_cen = cyc >= 10 && cyc <= 30;
      e_ov  = cyc == 29 || cyc == 30;
      e_of  = cyc == 29;
      e_ol  = 1'b0;
      e_idx = (cyc == 30) ? 4'd8 : 4'd0;
      e_rdy = cyc != 31;
      e_clr = cyc == 31;
      e_err = cyc == 31;
      e_fc  = 8'd0;
      step(cyc >= 10 && cyc <= 29);
    end
    do_reset();
    while (cyc <= 50) begin
      single(10);
      step((cyc >= 10 && cyc <= 25) || (cyc >= 30 && cyc <= 40));
    end
    do_reset();
    while (cyc <= 65) begin
      if (cyc == 20) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
      end else begin
        single(cyc < 20 ? 10 : 25);
        step((cyc >= 10 && cyc <= 19) || (cyc >= 25 && cyc <= 40));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
